// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - rx_state_e    : receiver FSM state encoding
//   - PAR_EVEN/ODD  : encodings of the PAR_TYP configuration input
//   - PRESCALE_*    : the oversampling ratios the receiver is built for
//   - *_DEF         : default frame / prescale widths
//   - maj3()        : 2-of-3 majority used by the bit sampler
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling timer and 3-sample majority vote.
//
// Ports:
//   clk, rst      : receiver clock, async active-high reset
//   count_en      : a frame is in progress (FSM not in IDLE)
//   start         : start bit seen in IDLE this cycle (this cycle is edge 0)
//   rx_in         : serial line, already synchronized
//   prescale      : oversampling ratio latched for the current frame
//   sampled_bit   : majority of the three mid-bit samples
//   bit_done      : last edge of the bit period (edge prescale-1)
//
// The samples are taken at edges P/2-1 and P/2, and the third sample at
// P/2+1 is folded straight into the vote flop, so sampled_bit is stable from
// edge P/2+2 until the next bit's vote.
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_en,
    input  logic                  start,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] half;
    logic                  samp_a_q, samp_a_d;
    logic                  samp_b_q, samp_b_d;
    logic                  sampled_bit_q, sampled_bit_d;

    assign last_edge = prescale - ONE;
    assign half      = prescale >> 1;

    always_comb begin
        edge_cnt_d    = edge_cnt_q;
        samp_a_d      = samp_a_q;
        samp_b_d      = samp_b_q;
        sampled_bit_d = sampled_bit_q;

        // The start cycle itself is edge 0, so the counter resumes at 1.
        if (start) begin
            edge_cnt_d = ONE;
        end else if (!count_en) begin
            edge_cnt_d = '0;
        end else if (edge_cnt_q == last_edge) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + ONE;
        end

        if (count_en) begin
            if (edge_cnt_q == half - ONE) begin
                samp_a_d = rx_in;
            end
            if (edge_cnt_q == half) begin
                samp_b_d = rx_in;
            end
            if (edge_cnt_q == half + ONE) begin
                sampled_bit_d = maj3(samp_a_q, samp_b_q, rx_in);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q    <= '0;
            samp_a_q      <= 1'b0;
            samp_b_q      <= 1'b0;
            sampled_bit_q <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            samp_a_q      <= samp_a_d;
            samp_b_q      <= samp_b_d;
            sampled_bit_q <= sampled_bit_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign bit_done    = count_en && (edge_cnt_q == last_edge);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start / DATA_WIDTH data bits (LSB first) /
// optional parity / one stop bit.
//
// Ports:
//   clk, rst      : oversampling clock, async active-high reset
//   RX_IN         : serial line, idle high, synchronized upstream
//   Prescale      : oversampling ratio (8, 16 or 32)
//   PAR_EN        : frame carries a parity bit
//   PAR_TYP       : 0 even, 1 odd parity
//   P_DATA        : last byte received without error
//   data_valid    : one-cycle pulse, P_DATA updated
//   parity_error  : one-cycle pulse, parity mismatch in the finished frame
//   framing_error : one-cycle pulse, stop bit was 0
//
// state  | meaning
// IDLE   | line idle, waiting for a low level (start bit edge 0)
// START  | timing the start bit; a high vote means a glitch, frame dropped
// DATA   | shifting in DATA_WIDTH bits, LSB first
// PARITY | comparing the parity bit against the received byte
// STOP   | checking the stop bit, then one extra cycle while the result
//        | pulses are on the outputs before returning to IDLE
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d;
    logic                  frame_end_q, frame_end_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  framing_error_q, framing_error_d;

    logic                  start_frame;
    logic                  count_en;
    logic                  sampled_bit;
    logic                  bit_done;
    logic                  fr_err;
    logic                  par_exp;

    assign count_en = (state_q != IDLE);
    assign fr_err   = !sampled_bit;
    assign par_exp  = (^shift_q) ^ (par_typ_q == PAR_ODD);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .count_en    (count_en),
        .start       (start_frame),
        .rx_in       (RX_IN),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done)
    );

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        prescale_d      = prescale_q;
        par_en_d        = par_en_q;
        par_typ_d       = par_typ_q;
        par_err_d       = par_err_q;
        frame_end_d     = 1'b0;
        p_data_d        = p_data_q;
        data_valid_d    = 1'b0;
        parity_error_d  = 1'b0;
        framing_error_d = 1'b0;
        start_frame     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    start_frame = 1'b1;
                    state_d     = START;
                    bit_cnt_d   = '0;
                    par_err_d   = 1'b0;
                    // Configuration is frozen for the whole frame.
                    prescale_d  = Prescale;
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                end
            end

            START: begin
                if (bit_done) begin
                    if (sampled_bit) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end

            DATA: begin
                if (bit_done) begin
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end

            PARITY: begin
                if (bit_done) begin
                    par_err_d = par_err_q | (sampled_bit != par_exp);
                    state_d   = STOP;
                end
            end

            STOP: begin
                // The cycle after the stop decision is the pulse cycle; the
                // FSM leaves only then, so a start bit that begins on the
                // pulse cycle is picked up in IDLE one cycle later.
                if (frame_end_q) begin
                    state_d = IDLE;
                end else if (bit_done) begin
                    frame_end_d     = 1'b1;
                    parity_error_d  = par_err_q;
                    framing_error_d = fr_err;
                    if (!par_err_q && !fr_err) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            prescale_q      <= PRESCALE_W'(PRESCALE_8);
            par_en_q        <= 1'b0;
            par_typ_q       <= PAR_EVEN;
            par_err_q       <= 1'b0;
            frame_end_q     <= 1'b0;
            p_data_q        <= '0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            prescale_q      <= prescale_d;
            par_en_q        <= par_en_d;
            par_typ_q       <= par_typ_d;
            par_err_q       <= par_err_d;
            frame_end_q     <= frame_end_d;
            p_data_q        <= p_data_d;
            data_valid_q    <= data_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign P_DATA        = p_data_q;
    assign data_valid    = data_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. Each frame driven onto RX_IN pushes its
// expected outcome (pulse cycle, flags, P_DATA) onto a queue; a negedge
// monitor pops and compares whenever any result pulse appears.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          framing_error;

    uart_rx #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .RX_IN         (rx_in),
        .Prescale      (prescale),
        .PAR_EN        (par_en),
        .PAR_TYP       (par_typ),
        .P_DATA        (p_data),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc_exp;
        logic          dv;
        logic          pe;
        logic          fe;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp     = 0;
    int            n_bad     = 0;
    int            ready_cyc = 0;
    logic [DW-1:0] last_good = '0;

    always @(posedge clk) begin
        assert (prescale == PW'(PRESCALE_8) || prescale == PW'(PRESCALE_16) ||
                prescale == PW'(PRESCALE_32))
        else $error("illegal Prescale value %0d driven", prescale);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse monitor: every pulse cycle must match the oldest pending frame.
    always @(negedge clk) begin
        if (data_valid || parity_error || framing_error) begin
            n_cmp++;
            assert (sb.size() > 0)
            else begin
                n_bad++;
                $error("FAIL unexpected_pulse: observed dv=%0b pe=%0b fe=%0b at cycle %0d, expected no pulse",
                       data_valid, parity_error, framing_error, cyc);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("pulse_cycle", cyc, mon_e.cyc_exp);
                chk("data_valid", {31'd0, data_valid}, {31'd0, mon_e.dv});
                chk("parity_error", {31'd0, parity_error}, {31'd0, mon_e.pe});
                chk("framing_error", {31'd0, framing_error}, {31'd0, mon_e.fe});
                chk("p_data", {24'd0, p_data}, {24'd0, mon_e.data});
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_p_data"}, {24'd0, p_data}, 32'd0);
        chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_parity_error"}, {31'd0, parity_error}, 32'd0);
        chk({tag, "_framing_error"}, {31'd0, framing_error}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Drives one frame with the current configuration. gpos/goff place a
    // one-cycle inverted glitch at frame bit gpos (0 = start bit), at the
    // receiver's edge goff of that bit; gpos < 0 means no glitch.
    // The configuration pins are flipped for the body of the frame to show
    // they are only taken at frame start.
    task automatic send_frame(input logic [DW-1:0] d, input logic pbit,
                              input logic sbit, input int gpos, input int goff);
        int            start;
        int            rx0;
        int            n;
        int            p;
        int            lag;
        logic          pen;
        logic          ptyp;
        logic [PW-1:0] psave;
        logic [10:0]   fr;
        logic          pe_exp;
        logic          fe_exp;
        exp_t          e;

        p     = int'(prescale);
        pen   = par_en;
        ptyp  = par_typ;
        psave = prescale;
        start = cyc;
        rx0   = (ready_cyc > start) ? ready_cyc : start;
        lag   = rx0 - start;
        n     = pen ? 11 : 10;

        fr = '1;
        fr[0] = 1'b0;
        for (int k = 0; k < DW; k++) fr[k+1] = d[k];
        if (pen) begin
            fr[9]  = pbit;
            fr[10] = sbit;
        end else begin
            fr[9] = sbit;
        end

        pe_exp = pen && (pbit != ((^d) ^ (ptyp == PAR_ODD)));
        fe_exp = !sbit;
        e.cyc_exp = rx0 + n * p;
        e.dv      = !pe_exp && !fe_exp;
        e.pe      = pe_exp;
        e.fe      = fe_exp;
        if (e.dv) last_good = d;
        e.data    = last_good;
        sb.push_back(e);
        ready_cyc = e.cyc_exp + 1;

        for (int i = 0; i < n; i++) begin
            if (i == 1) begin
                par_en   = ~pen;
                par_typ  = ~ptyp;
                prescale = (p == PRESCALE_16) ? PW'(PRESCALE_8) : PW'(PRESCALE_16);
            end
            for (int j = 0; j < p; j++) begin
                rx_in = (i == gpos && j == goff + lag) ? ~fr[i] : fr[i];
                tick(1);
            end
        end
        par_en   = pen;
        par_typ  = ptyp;
        prescale = psave;
        rx_in    = 1'b1;
    endtask

    initial begin
        int gstart;

        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = PW'(PRESCALE_8);
        par_en   = 1'b0;
        par_typ  = PAR_EVEN;
        tick(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick(5);

        // Prescale 8, even parity, good frame.
        prescale = PW'(PRESCALE_8);
        par_en   = 1'b1;
        par_typ  = PAR_EVEN;
        tick(3);
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
        tick(10);

        // Prescale 16, odd parity, wrong parity bit.
        prescale = PW'(PRESCALE_16);
        par_en   = 1'b1;
        par_typ  = PAR_ODD;
        tick(3);
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0);
        tick(10);

        // Prescale 32, no parity: bad stop bit then a back-to-back good frame.
        prescale = PW'(PRESCALE_32);
        par_en   = 1'b0;
        par_typ  = PAR_EVEN;
        tick(3);
        send_frame(8'h81, 1'b0, 1'b0, -1, 0);
        send_frame(8'h55, 1'b0, 1'b1, -1, 0);
        tick(10);

        // Prescale 16: short low glitch is rejected, then a normal frame.
        prescale = PW'(PRESCALE_16);
        tick(3);
        gstart = cyc;
        rx_in  = 1'b0;
        tick(4);
        rx_in  = 1'b1;
        ready_cyc = gstart + 16;
        tick(40);
        send_frame(8'h0F, 1'b0, 1'b1, -1, 0);
        tick(10);

        // Prescale 8: three chained frames, one middle-sample glitch in 0xFF.
        prescale = PW'(PRESCALE_8);
        par_en   = 1'b0;
        tick(3);
        send_frame(8'h01, 1'b0, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 5, PRESCALE_8 / 2);
        send_frame(8'h80, 1'b0, 1'b1, -1, 0);
        tick(10);

        // Reset in the middle of a 0xC3 frame, then 0x5A.
        prescale = PW'(PRESCALE_16);
        tick(3);
        rx_in = 1'b0;
        tick(16);
        rx_in = 1'b1;
        tick(16);
        rx_in = 1'b1;
        tick(16);
        rx_in = 1'b0;
        tick(5);
        rst = 1'b1;
        last_good = '0;
        tick(1);
        chk_outputs_zero("midreset");
        rx_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        ready_cyc = cyc;
        send_frame(8'h5A, 1'b0, 1'b1, -1, 0);

        for (int w = 0; w < 2000 && sb.size() > 0; w++) tick(1);
        tick(20);
        n_cmp++;
        assert (sb.size() == 0)
        else begin
            n_bad++;
            $error("FAIL pending_frames: observed %0d outstanding expected 0", sb.size());
        end
        @(negedge clk);
        chk("final_p_data", {24'd0, p_data}, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the downstream counterpart of the UART transmitter; it consumes the serial line (Tx_out on the far side).
- Oversamples RX_IN by a runtime prescale and majority-votes each bit.
- Checks the optional parity bit and the stop bit.
- Delivers each good byte as a one-cycle data_valid pulse with P_DATA.
- Sits between the pad-side synchronizer and the RX-side clock-domain FIFO / system controller.

Parameters:
DATA_WIDTH, 8, payload bits per frame (LSB first)
PRESCALE_W, 6, width of Prescale input

Ports:
clk  input  1  receiver clock (oversampling clock)
rst  input  1  reset, asynchronous, active-high
RX_IN  input  1  serial line, idle high; already 2-flop synchronized upstream, block adds no synchronizer
Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries parity bit
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last good received byte
data_valid  output  1  one-cycle pulse, P_DATA valid
parity_error  output  1  one-cycle pulse, parity mismatch
framing_error  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset: state IDLE; edge_cnt, bit_cnt and shift register 0; P_DATA=0; data_valid=0; parity_error=0; framing_error=0. Asynchronous assert, synchronous release.
- Configuration latch: Prescale, PAR_EN and PAR_TYP are latched on IDLE->START. Changes mid-frame have no effect on the current frame.
- edge_cnt: counts 0..Prescale-1 within each bit. The first cycle RX_IN is seen low in IDLE is edge 0 of the start bit.
- Sampling: RX_IN is sampled at edges Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the 3 samples, registered by edge Prescale/2+2.
- Bit decisions are taken at edge Prescale-1.
- States:
  - IDLE: RX_IN==0 -> START, edge_cnt=1 next cycle.
  - START: at last edge, voted bit 1 (glitch) -> IDLE with no flags; else -> DATA, bit_cnt=0.
  - DATA: at each last edge, shift the voted bit into the MSB of the shift register (LSB-first reception); bit_cnt+1. After DATA_WIDTH bits -> PARITY if the latched PAR_EN, else STOP.
  - PARITY: expected bit = XOR(data) ^ PAR_TYP. Mismatch is stored in a sticky par_err register, cleared on entry to START. -> STOP.
  - STOP: at last edge, fr_err = (voted bit==0).
    - Next cycle: if !par_err && !fr_err then P_DATA<=shift, data_valid=1; else P_DATA is held and data_valid=0.
    - parity_error=par_err and framing_error=fr_err pulse in that same cycle; both may be 1 together.
    - -> IDLE.
- Latency: the output pulse occurs on cycle N*Prescale, where edge 0 = cycle 0, N=11 with parity, N=10 without.
- Back-to-back frames: a start bit beginning on the pulse cycle is detected in IDLE one cycle later. The one-cycle phase lag is within the sampling tolerance, so no frame is lost.
- Outputs are registered; no combinational path from RX_IN to any output.
- Tolerance: a frame whose bit period differs from Prescale clocks by up to ±3% is received correctly.
- Prescale other than 8/16/32: behaviour undefined; the bench flags it with an assertion.
- Reset mid-frame: immediate return to IDLE, all outputs 0, partial byte discarded.
- A line held low continuously gives a framing_error pulse, then a new START on the next cycle. This repeats every frame time while the line stays low.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP)
  - PAR_EVEN/PAR_ODD constants
  - legal prescale constants 8/16/32
  - DATA_WIDTH default
- One sub-module, uart_rx_sampler:
  - holds edge_cnt and the 3-sample majority vote
  - outputs sampled_bit and bit_done (edge Prescale-1)
- The FSM, shift register, parity and stop checks stay in uart_rx.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with even parity bit 0 -> data_valid pulse at cycle 88, P_DATA=0xA5, no errors.
- Prescale=16, PAR_EN=1, PAR_TYP=1, send 0x3C with parity bit wrong (0) -> parity_error pulse at cycle 176, data_valid=0, P_DATA unchanged.
- Prescale=32, PAR_EN=0, send 0x81 with stop bit 0 -> framing_error pulse at cycle 320; then 0x55 back-to-back with a correct stop -> data_valid, P_DATA=0x55.
- Prescale=16, RX_IN low for 4 cycles, then high -> returns to IDLE, no pulses; a following 0x0F frame is received correctly.
- Prescale=8, 3 back-to-back frames 0x01, 0xFF, 0x80, each bit period 8 cycles with a single-cycle glitch on a middle sample of one data bit -> 3 data_valid pulses with correct bytes.
- rst asserted mid-DATA of a 0xC3 frame, released, then 0x5A sent -> no pulse for 0xC3, 0x5A received; all outputs 0 during reset.
